// File: rtl/core_pkg.sv
// Shared core types: fetch FSM encoding and fetch-queue entry layout.
// Entry address fields are core_pkg::XLEN wide; fetch_unit's XLEN must not exceed it.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_FETCH,
    FS_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]   instr;
    logic [XLEN-1:0] pc;
    logic          pred_taken;
    logic [XLEN-1:0] pred_target;
    logic          filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation with same-cycle branch prediction, in-order
// imem requests, and a fetch queue that reserves slots at request time.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            predict_req,
  output logic [XLEN-1:0] predict_pc,
  input  logic            predict_taken,
  input  logic [XLEN-1:0] predict_target,
  input  logic            predict_valid,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fq_valid,
  input  logic            fq_ready,
  output logic [31:0]     fq_instr,
  output logic [XLEN-1:0] fq_pc,
  output logic            fq_pred_taken,
  output logic [XLEN-1:0] fq_pred_target
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = core_pkg::XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [CW-1:0]   used_q, used_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  fq_entry_t       slots_q [FQ_DEPTH];
  fq_entry_t       slots_d [FQ_DEPTH];

  logic      req_fire, pred_hit, resp_take, resp_keep, deq_fire;
  fq_entry_t head;

  // used_q counts reserved plus filled slots, so it bounds new requests.
  assign imem_req_valid = (state_q == FS_FETCH) && (used_q < CW'(FQ_DEPTH)) && !redirect_en;
  assign imem_req_addr  = pc_q;
  assign predict_req    = imem_req_valid;
  assign predict_pc     = pc_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pred_hit  = predict_taken && predict_valid;
  assign resp_take = imem_resp_valid && (inflight_q != '0);
  assign resp_keep = resp_take && (state_q == FS_FETCH) && !redirect_en;

  assign head           = slots_q[rd_ptr_q];
  assign fq_valid       = head.filled;
  assign fq_instr       = head.instr;
  assign fq_pc          = XLEN'(head.pc);
  assign fq_pred_taken  = head.pred_taken;
  assign fq_pred_target = XLEN'(head.pred_target);
  assign deq_fire       = fq_valid && fq_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    alloc_ptr_d = alloc_ptr_q;
    used_d      = used_q;
    slots_d     = slots_q;
    inflight_d  = inflight_q + CW'(req_fire) - CW'(resp_take);

    if (redirect_en) begin
      pc_d        = redirect_pc;
      slots_d     = '{default: '0};
      rd_ptr_d    = '0;
      fill_ptr_d  = '0;
      alloc_ptr_d = '0;
      used_d      = '0;
      state_d     = ((state_q == FS_DRAIN) || (inflight_d != '0)) ? FS_DRAIN : FS_FETCH;
    end else begin
      // Dequeue, fill and reserve always touch distinct slots.
      if (deq_fire) begin
        slots_d[rd_ptr_q].filled = 1'b0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (resp_keep) begin
        slots_d[fill_ptr_q].instr  = imem_resp_data;
        slots_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (req_fire) begin
        slots_d[alloc_ptr_q].instr       = '0;
        slots_d[alloc_ptr_q].pc          = EW'(pc_q);
        slots_d[alloc_ptr_q].pred_taken  = pred_hit;
        slots_d[alloc_ptr_q].pred_target = EW'(predict_target);
        slots_d[alloc_ptr_q].filled      = 1'b0;
        alloc_ptr_d = alloc_ptr_q + PW'(1);
        pc_d = pred_hit ? predict_target : pc_q + XLEN'(4);
      end
      used_d = used_q + CW'(req_fire) - CW'(deq_fire);

      unique case (state_q)
        FS_BOOT:  state_d = FS_FETCH;
        FS_FETCH: state_d = FS_FETCH;
        FS_DRAIN: state_d = (inflight_d == '0) ? FS_FETCH : FS_DRAIN;
        default:  state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FS_BOOT;
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      fill_ptr_q  <= '0;
      alloc_ptr_q <= '0;
      used_q      <= '0;
      inflight_q  <= '0;
      slots_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      alloc_ptr_q <= alloc_ptr_d;
      used_q      <= used_d;
      inflight_q  <= inflight_d;
      slots_q     <= slots_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && imem_resp_valid && (inflight_q == '0))
      $error("fetch_unit: imem response with no request in flight");
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven fetch streams plus backpressure,
// redirect/drain, streaming and mid-stream reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        predict_req;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        predict_valid;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_pred_taken;
  logic [31:0] fq_pred_target;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .predict_req(predict_req), .predict_pc(predict_pc), .predict_taken(predict_taken),
    .predict_target(predict_target), .predict_valid(predict_valid),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_instr(fq_instr), .fq_pc(fq_pc),
    .fq_pred_taken(fq_pred_taken), .fq_pred_target(fq_pred_target)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] tgt; logic taken; } ent_t;
  typedef struct {
    logic [31:0] hpc;
    logic [31:0] htgt;
    logic        htk;
    logic        hvl;
    logic [4:0][31:0] epc;
    logic [4:0]       etk;
    logic [4:0][31:0] etgt;
  } vec_t;

  pend_t       pend[$];
  ent_t        got[$];
  int unsigned cyc = 0, nreq = 0, lat = 1, n_triple = 0;
  int unsigned n_cmp = 0, n_bad = 0;
  logic        resp_en = 1'b1;
  logic [31:0] hit_pc = 32'h1000, hit_tgt = '0;
  logic        hit_taken = 1'b0, hit_valid = 1'b0;
  logic        last_req_v;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive memory/predictor, record handshakes just before the edge.
  task automatic step();
    logic rv;
    rv = resp_en && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? instr_of(pend[0].addr) : 32'h0;
    if (predict_pc == hit_pc) begin
      predict_taken = hit_taken; predict_valid = hit_valid; predict_target = hit_tgt;
    end else begin
      predict_taken = 1'b0; predict_valid = 1'b0; predict_target = 32'h0;
    end
    #1;
    last_req_v    = imem_req_valid;
    last_req_addr = imem_req_addr;
    if (rv && imem_req_valid && imem_req_ready && fq_valid && fq_ready) n_triple++;
    if (rv) void'(pend.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      nreq++;
    end
    if (fq_valid && fq_ready)
      got.push_back('{pc: fq_pc, instr: fq_instr, tgt: fq_pred_target, taken: fq_pred_taken});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'h0);
    chk({tag, ".predict_req"}, 32'(predict_req), 32'h0);
    chk({tag, ".req_addr"}, imem_req_addr, 32'h0);
    chk({tag, ".predict_pc"}, predict_pc, 32'h0);
    chk({tag, ".fq_valid"}, 32'(fq_valid), 32'h0);
    chk({tag, ".fq_instr"}, fq_instr, 32'h0);
    chk({tag, ".fq_pc"}, fq_pc, 32'h0);
    chk({tag, ".fq_pred_taken"}, 32'(fq_pred_taken), 32'h0);
    chk({tag, ".fq_pred_target"}, fq_pred_target, 32'h0);
  endtask

  task automatic do_reset(input bit check);
    reset_n = 1'b0;
    redirect_en = 1'b0;
    pend.delete();
    got.delete();
    nreq = 0;
    #1;
    if (check) check_zero("reset");
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic collect(input int unsigned n, input string tag);
    for (int unsigned k = 0; k < 80 && got.size() < n; k++) step();
    chk({tag, ".collected"}, 32'(got.size() >= n), 32'h1);
  endtask

  initial begin
    vec_t vt[5];
    vt[0] = '{hpc: 32'h1000, htgt: 32'h0, htk: 1'b0, hvl: 1'b0,
              epc: {32'h10, 32'hC, 32'h8, 32'h4, 32'h0}, etk: 5'b00000,
              etgt: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vt[1] = '{hpc: 32'h8, htgt: 32'h100, htk: 1'b1, hvl: 1'b1,
              epc: {32'h104, 32'h100, 32'h8, 32'h4, 32'h0}, etk: 5'b00100,
              etgt: {32'h0, 32'h0, 32'h100, 32'h0, 32'h0}};
    vt[2] = '{hpc: 32'h4, htgt: 32'h40, htk: 1'b1, hvl: 1'b0,
              epc: {32'h10, 32'hC, 32'h8, 32'h4, 32'h0}, etk: 5'b00000,
              etgt: {32'h0, 32'h0, 32'h0, 32'h40, 32'h0}};
    vt[3] = '{hpc: 32'h0, htgt: 32'h0, htk: 1'b1, hvl: 1'b1,
              epc: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, etk: 5'b11111,
              etgt: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vt[4] = '{hpc: 32'h4, htgt: 32'hFFFF_FFF8, htk: 1'b1, hvl: 1'b1,
              epc: {32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h4, 32'h0}, etk: 5'b00010,
              etgt: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0}};

    reset_n = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    predict_taken = 1'b0; predict_valid = 1'b0; predict_target = '0;
    redirect_en = 1'b0; redirect_pc = '0; fq_ready = 1'b1;
    @(negedge clk);

    // Table-driven fetch streams, including reset values and first-request latency.
    for (int v = 0; v < 5; v++) begin
      hit_pc = vt[v].hpc; hit_tgt = vt[v].htgt; hit_taken = vt[v].htk; hit_valid = vt[v].hvl;
      lat = 1; resp_en = 1'b1; fq_ready = 1'b1;
      do_reset(v == 0);
      step();
      chk($sformatf("v%0d.boot_cycle_req", v), 32'(last_req_v), 32'h0);
      step();
      chk($sformatf("v%0d.cycle2_req", v), 32'(last_req_v), 32'h1);
      chk($sformatf("v%0d.cycle2_addr", v), last_req_addr, 32'h0);
      collect(5, $sformatf("v%0d", v));
      for (int i = 0; i < 5; i++) begin
        if (got.size() > i) begin
          chk($sformatf("v%0d.pc[%0d]", v, i), got[i].pc, vt[v].epc[i]);
          chk($sformatf("v%0d.instr[%0d]", v, i), got[i].instr, instr_of(vt[v].epc[i]));
          chk($sformatf("v%0d.taken[%0d]", v, i), 32'(got[i].taken), 32'(vt[v].etk[i]));
          chk($sformatf("v%0d.target[%0d]", v, i), got[i].tgt, vt[v].etgt[i]);
        end
      end
    end
    hit_pc = 32'h1000; hit_taken = 1'b0; hit_valid = 1'b0; hit_tgt = '0;

    // Backpressure: queue fills to exactly FQ_DEPTH, one dequeue frees one request.
    lat = 1; resp_en = 1'b1; fq_ready = 1'b0;
    do_reset(0);
    repeat (20) step();
    chk("bp.requests_full", nreq, 32'd4);
    chk("bp.req_valid_full", 32'(last_req_v), 32'h0);
    fq_ready = 1'b1;
    step();
    fq_ready = 1'b0;
    repeat (10) step();
    chk("bp.requests_after_deq", nreq, 32'd5);
    chk("bp.dequeued", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("bp.deq_pc", got[0].pc, 32'h0);
    chk("bp.req_valid_refull", 32'(last_req_v), 32'h0);

    // Redirect with a stale filled entry and two requests in flight.
    lat = 2; resp_en = 1'b1; fq_ready = 1'b0;
    do_reset(0);
    for (int unsigned k = 0; k < 20 && nreq < 3; k++) step();
    chk("rd.requests", nreq, 32'd3);
    chk("rd.stale_present", 32'(fq_valid), 32'h1);
    resp_en = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    chk("rd.no_req_on_redirect", 32'(last_req_v), 32'h0);
    redirect_en = 1'b0;
    chk("rd.fq_valid_cleared", 32'(fq_valid), 32'h0);
    chk("rd.inflight_pending", 32'(pend.size()), 32'd2);
    resp_en = 1'b1; fq_ready = 1'b1;
    step();
    chk("rd.drain0_no_req", 32'(last_req_v), 32'h0);
    step();
    chk("rd.drain1_no_req", 32'(last_req_v), 32'h0);
    chk("rd.drained", 32'(pend.size()), 32'd0);
    step();
    chk("rd.refetch_req", 32'(last_req_v), 32'h1);
    chk("rd.refetch_addr", last_req_addr, 32'h200);
    collect(2, "rd");
    if (got.size() > 1) begin
      chk("rd.first_pc", got[0].pc, 32'h200);
      chk("rd.first_instr", got[0].instr, instr_of(32'h200));
      chk("rd.second_pc", got[1].pc, 32'h204);
    end

    // Steady stream at occupancy FQ_DEPTH-1 with request, response and dequeue together.
    lat = 2; resp_en = 1'b1; fq_ready = 1'b1;
    do_reset(0);
    n_triple = 0;
    repeat (30) step();
    chk("st.triple_cycles>=20", 32'(n_triple >= 20), 32'h1);
    chk("st.count>=20", 32'(got.size() >= 20), 32'h1);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("st.pc[%0d]", i), got[i].pc, 32'(4 * i));
      chk($sformatf("st.instr[%0d]", i), got[i].instr, instr_of(32'(4 * i)));
    end

    // Asynchronous reset mid-stream.
    lat = 1; resp_en = 1'b1; fq_ready = 1'b1;
    do_reset(0);
    repeat (8) step();
    chk("mr.pre_fq_valid", 32'(fq_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    check_zero("mr");
    pend.delete(); got.delete(); nreq = 0;
    step();
    step();
    reset_n = 1'b1;
    collect(2, "mr");
    if (got.size() > 1) begin
      chk("mr.first_pc", got[0].pc, 32'h0);
      chk("mr.second_pc", got[1].pc, 32'h4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_fetch_unit timeout");
  end

endmodule
